// File: rtl/carregador_serial_if.sv
// Handshake bundle between the serial loader and its neighbours.
// Ports:
//   inicio, dado_serial          frame start strobe and serial data/parity bit
//   palavra                      last correctly received word
//   enable_reg                   one-cycle load strobe for the register stage
//   ocupado, erro_paridade       frame-in-progress and sticky parity error flags
// The slave modport is the loader's view; master is the driving/observing side.
interface carregador_serial_if #(
  parameter int LARGURA = 4
);
  logic               inicio;
  logic               dado_serial;
  logic [LARGURA-1:0] palavra;
  logic               enable_reg;
  logic               ocupado;
  logic               erro_paridade;

  modport master (
    output inicio, dado_serial,
    input  palavra, enable_reg, ocupado, erro_paridade
  );

  modport slave (
    input  inicio, dado_serial,
    output palavra, enable_reg, ocupado, erro_paridade
  );
endinterface

// File: rtl/carregador_serial.sv
// Serial-to-parallel loader feeding the 4-bit register stage (entrada/enable).
// Captures a frame of start strobe, LARGURA data bits LSB first and one parity
// bit. A good frame updates palavra and pulses enable_reg for one cycle; a bad
// frame sets the sticky erro_paridade flag and leaves palavra untouched.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-low reset
//   bus   carregador_serial_if.slave (inicio, dado_serial in; palavra,
//         enable_reg, ocupado, erro_paridade out, all registered)
//
// state    | meaning
// OCIOSO   | idle, waiting for inicio
// DADOS    | shifting in data bits, LSB first
// PARIDADE | sampling parity bit, deciding load or error
// ENTREGA  | strobe cycle, then back to idle
module carregador_serial #(
  parameter int LARGURA      = 4,
  parameter bit PARIDADE_PAR = 1'b1
) (
  input  logic clk,
  input  logic rst,
  carregador_serial_if.slave bus
);
  localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;

  typedef enum logic [1:0] {OCIOSO, DADOS, PARIDADE, ENTREGA} estado_t;

  estado_t            estado, estado_prox;
  logic [LARGURA-1:0] buffer_q, buffer_d;
  logic [LARGURA-1:0] palavra_q, palavra_d;
  logic [CW-1:0]      cont_q, cont_d;
  logic               enable_q, enable_d;
  logic               ocupado_q, ocupado_d;
  logic               erro_q, erro_d;
  logic               paridade_ok;

  // Even parity needs a zero XOR over data+parity, odd needs one; folding the
  // parameter into the XOR makes "ok" a single 1 in both cases.
  assign paridade_ok = (^buffer_q) ^ bus.dado_serial ^ PARIDADE_PAR;

  always_ff @(posedge clk) begin
    if (!rst) begin
      estado    <= OCIOSO;
      buffer_q  <= '0;
      cont_q    <= '0;
      palavra_q <= '0;
      enable_q  <= 1'b0;
      ocupado_q <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      estado    <= estado_prox;
      buffer_q  <= buffer_d;
      cont_q    <= cont_d;
      palavra_q <= palavra_d;
      enable_q  <= enable_d;
      ocupado_q <= ocupado_d;
      erro_q    <= erro_d;
    end
  end

  always_comb begin
    estado_prox = estado;
    buffer_d    = buffer_q;
    cont_d      = cont_q;
    palavra_d   = palavra_q;
    enable_d    = 1'b0;
    erro_d      = erro_q;

    case (estado)
      OCIOSO: begin
        if (bus.inicio) begin
          estado_prox = DADOS;
          cont_d      = '0;
          erro_d      = 1'b0;
        end
      end
      DADOS: begin
        buffer_d[cont_q] = bus.dado_serial;
        cont_d           = cont_q + CW'(1);
        if (cont_q == CW'(LARGURA - 1)) begin
          estado_prox = PARIDADE;
        end
      end
      PARIDADE: begin
        if (paridade_ok) begin
          palavra_d = buffer_q;
          enable_d  = 1'b1;
        end else begin
          erro_d = 1'b1;
        end
        estado_prox = ENTREGA;
      end
      ENTREGA: begin
        estado_prox = OCIOSO;
      end
      default: begin
        estado_prox = OCIOSO;
      end
    endcase

    ocupado_d = (estado_prox != OCIOSO);
  end

  assign bus.palavra       = palavra_q;
  assign bus.enable_reg    = enable_q;
  assign bus.ocupado       = ocupado_q;
  assign bus.erro_paridade = erro_q;
endmodule

// File: tb/tb_carregador_serial.sv
module tb_carregador_serial;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inicio = 1'b0;
  logic dado_serial = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  carregador_serial_if #(.LARGURA(4)) if_e ();
  carregador_serial_if #(.LARGURA(4)) if_o ();

  assign if_e.inicio      = inicio;
  assign if_e.dado_serial = dado_serial;
  assign if_o.inicio      = inicio;
  assign if_o.dado_serial = dado_serial;

  carregador_serial #(.LARGURA(4), .PARIDADE_PAR(1'b1)) dut_e (
    .clk (clk),
    .rst (rst),
    .bus (if_e.slave)
  );

  carregador_serial #(.LARGURA(4), .PARIDADE_PAR(1'b0)) dut_o (
    .clk (clk),
    .rst (rst),
    .bus (if_o.slave)
  );

  // Scoreboard: expected words per instance, pushed when a good frame is sent.
  logic [3:0] q_e[$];
  logic [3:0] q_o[$];
  logic [3:0] pal_e = 4'h0, pal_o = 4'h0;
  logic       err_e = 1'b0, err_o = 1'b0;
  int         strobes_e = 0, strobes_o = 0;
  int         exp_strobes_e = 0, exp_strobes_o = 0;
  logic       prev_en_e = 1'b0, prev_en_o = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Strobe monitor: every strobe must match the oldest queued word.
  always @(negedge clk) begin
    if (if_e.enable_reg === 1'b1) begin
      strobes_e++;
      if (q_e.size() == 0) check("even_unexpected_strobe", 32'd1, 32'd0);
      else check("even_strobe_palavra", {28'd0, if_e.palavra}, {28'd0, q_e.pop_front()});
      if (prev_en_e) check("even_strobe_width", 32'd2, 32'd1);
    end
    if (if_o.enable_reg === 1'b1) begin
      strobes_o++;
      if (q_o.size() == 0) check("odd_unexpected_strobe", 32'd1, 32'd0);
      else check("odd_strobe_palavra", {28'd0, if_o.palavra}, {28'd0, q_o.pop_front()});
      if (prev_en_o) check("odd_strobe_width", 32'd2, 32'd1);
    end
    prev_en_e = (if_e.enable_reg === 1'b1);
    prev_en_o = (if_o.enable_reg === 1'b1);
  end

  task automatic check_all(input string tag, input logic [3:0] pe, input logic [3:0] po,
                           input logic en_e, input logic en_o, input logic oc,
                           input logic ee, input logic eo);
    check({tag, "_pal_e"}, {28'd0, if_e.palavra}, {28'd0, pe});
    check({tag, "_pal_o"}, {28'd0, if_o.palavra}, {28'd0, po});
    check({tag, "_en_e"},  {31'd0, if_e.enable_reg}, {31'd0, en_e});
    check({tag, "_en_o"},  {31'd0, if_o.enable_reg}, {31'd0, en_o});
    check({tag, "_oc_e"},  {31'd0, if_e.ocupado}, {31'd0, oc});
    check({tag, "_oc_o"},  {31'd0, if_o.ocupado}, {31'd0, oc});
    check({tag, "_err_e"}, {31'd0, if_e.erro_paridade}, {31'd0, ee});
    check({tag, "_err_o"}, {31'd0, if_o.erro_paridade}, {31'd0, eo});
  endtask

  // Sends one full frame starting at the current negedge (input setup for E0).
  // ini_mask[k] drives inicio at edge Ek for k=1..6 (ignored mid-frame).
  task automatic frame(input string tag, input logic [3:0] d, input logic p,
                       input logic [6:0] ini_mask);
    logic good_e, good_o;
    good_e = ((^d) ^ p) == 1'b0;
    good_o = ((^d) ^ p) == 1'b1;
    if (good_e) begin q_e.push_back(d); exp_strobes_e++; end
    if (good_o) begin q_o.push_back(d); exp_strobes_o++; end
    for (int e = 0; e <= 6; e++) begin
      inicio      = (e == 0) ? 1'b1 : ini_mask[e];
      dado_serial = (e == 0) ? 1'b1 : (e <= 4) ? d[e-1] : (e == 5) ? p : 1'b0;
      @(negedge clk);
      if (e == 0) begin
        err_e = 1'b0;
        err_o = 1'b0;
        check_all({tag, "_e0"}, pal_e, pal_o, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end else if (e == 5) begin
        if (good_e) pal_e = d; else err_e = 1'b1;
        if (good_o) pal_o = d; else err_o = 1'b1;
        check_all({tag, "_e5"}, pal_e, pal_o, good_e, good_o, 1'b1, err_e, err_o);
      end else if (e == 6) begin
        check_all({tag, "_e6"}, pal_e, pal_o, 1'b0, 1'b0, 1'b0, err_e, err_o);
      end else begin
        check_all({tag, "_data"}, pal_e, pal_o, 1'b0, 1'b0, 1'b1, err_e, err_o);
      end
    end
    inicio      = 1'b0;
    dado_serial = 1'b0;
  endtask

  initial begin
    // Reset with inicio/dado high: must stay idle with zero outputs.
    rst = 1'b0; inicio = 1'b1; dado_serial = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_all("reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b1; inicio = 1'b0; dado_serial = 1'b0;
    @(negedge clk);
    check_all("idle", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Bits 1,0,1,1 parity 1: good for even (D), bad for odd.
    frame("good_d", 4'hD, 1'b1, 7'b0);
    @(negedge clk);
    // Bits 0,1,0,0 parity 0: bad for even (holds D), good for odd.
    frame("bad_2", 4'h2, 1'b0, 7'b0);
    @(negedge clk);
    // Bits 1,1,1,1 parity 1: odd loads F; even sees error again.
    frame("odd_f", 4'hF, 1'b1, 7'b0);
    @(negedge clk);
    // Bits 0,0,1,0 parity 1 with inicio at E2 and E6; even clears error and loads 4.
    frame("ign_4", 4'h4, 1'b1, 7'b1000100);
    // Next frame accepted right at E7: bits 0,1,0,1 parity 0.
    frame("e7_a", 4'hA, 1'b0, 7'b0);
    @(negedge clk);

    // Reset at E3 of a frame: partial frame discarded, no strobe.
    inicio = 1'b1; dado_serial = 1'b1;
    @(negedge clk);
    inicio = 1'b0; dado_serial = 1'b1;
    @(negedge clk);
    dado_serial = 1'b1;
    @(negedge clk);
    rst = 1'b0; dado_serial = 1'b1;
    @(negedge clk);
    pal_e = 4'h0; pal_o = 4'h0; err_e = 1'b0; err_o = 1'b0;
    check_all("rst_mid", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; dado_serial = 1'b0;
    @(negedge clk);
    check_all("post_rst", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Bits 0,1,1,0 parity 0: even loads 6.
    frame("good_6", 4'h6, 1'b0, 7'b0);

    // Long idle: palavra holds, no stray strobes.
    repeat (5) @(negedge clk);
    check_all("hold", pal_e, pal_o, 1'b0, 1'b0, 1'b0, err_e, err_o);
    check("even_strobe_count", strobes_e, exp_strobes_e);
    check("odd_strobe_count", strobes_o, exp_strobes_o);
    check("even_queue_drained", q_e.size(), 0);
    check("odd_queue_drained", q_o.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/carregador_serial.md
Name: carregador_serial

Overview:
Serial-to-parallel loader that sits directly upstream of the 4-bit register stage and drives its entrada/enable pair. It captures a framed serial word (start strobe, LARGURA data bits LSB first, one parity bit) and checks parity. On a good frame it presents the word plus a one-cycle load strobe; on a bad frame it flags an error and issues no strobe.

Parameters:
LARGURA, 4, number of data bits per frame and width of palavra
PARIDADE_PAR, 1, 1 = even parity (XOR of data bits and parity bit must be 0); 0 = odd parity (XOR must be 1)

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  synchronous active-low reset, sampled on rising edge of clk
inicio  input  1  frame start strobe; honoured only in OCIOSO
dado_serial  input  1  serial data/parity bit, sampled on rising edge
palavra  output  LARGURA  last correctly received word; feeds register entrada
enable_reg  output  1  one-cycle load strobe; feeds register enable
ocupado  output  1  high while a frame is in progress (DADOS, PARIDADE, ENTREGA)
erro_paridade  output  1  set on parity mismatch; sticky until next accepted frame or reset

Behaviour:
- Reset: rst==0 at rising edge -> state OCIOSO, shift buffer=0, bit counter=0, palavra=0, enable_reg=0, ocupado=0, erro_paridade=0. Reset wins over every other event.
- All outputs are registered; no combinational path from inputs to outputs.
- States: OCIOSO, DADOS, PARIDADE, ENTREGA.
- OCIOSO: if inicio==1 at edge E0 -> DADOS, counter=0, erro_paridade cleared, ocupado=1 after E0. dado_serial at E0 is ignored. If inicio==0, stay.
- DADOS: edges E1..E(LARGURA) sample dado_serial into buffer bit [counter], LSB first. Counter increments. After the edge where counter==LARGURA-1 -> PARIDADE.
- PARIDADE: edge E(LARGURA+1) samples the parity bit and compares it with the buffer -> ENTREGA.
  - Match: palavra<=buffer, enable_reg<=1.
  - Mismatch: palavra unchanged, enable_reg stays 0, erro_paridade<=1.
- ENTREGA: lasts one cycle. At edge E(LARGURA+2): enable_reg<=0, ocupado<=0 -> OCIOSO.
- Timing (LARGURA=4): enable_reg is high strictly between E5 and E6, so the downstream register captures palavra at E6. ocupado is high from after E0 to after E6.
- inicio during DADOS, PARIDADE or ENTREGA is ignored and does not restart the frame. Earliest next accepted inicio is at E7.
- Reset mid-frame: the partial frame is discarded, outputs return to reset values, and no strobe is issued.
- palavra holds its value indefinitely between good frames.
- enable_reg never stays high for more than one consecutive cycle.

Test Plan:
1. Reset: rst=0 for 2 edges with inicio=1 and dado_serial=1 -> palavra=0, enable_reg=0, ocupado=0, erro_paridade=0 throughout, state remains OCIOSO.
2. Good frame (even parity): inicio at E0, bits 1,0,1,1 at E1..E4, parity 1 at E5 -> palavra=4'hD and enable_reg=1 only between E5 and E6; ocupado low after E6; erro_paridade=0.
3. Bad parity: after scenario 2, send bits 0,1,0,0 then parity 0 -> erro_paridade=1 after E5, palavra stays 4'hD, enable_reg never asserts.
4. Error clear + odd parity (PARIDADE_PAR=0 instance): bits 1,1,1,1, parity 1 -> palavra=4'hF, strobe issued, erro_paridade=0. Separately, a new accepted inicio clears a prior error on the E0 edge.
5. Ignored start: pulse inicio=1 at E2 and E6 during a frame carrying 0,0,1,0 with parity 1 -> single frame only, palavra=4'h4, exactly one strobe; inicio at E7 starts a new frame.
6. Reset mid-frame: rst=0 at E3 of a frame -> all outputs 0 after E3, no strobe. The following full frame 0,1,1,0 with parity 0 loads palavra=4'h6.
